// File: rtl/obb_integrator.sv
// Per-frame physics step for one OBB body: gravity, saturation, damping,
// integration and wall bounce, written back through the register's load port.
module obb_integrator #(
  parameter int GRAVITY    = 16,
  parameter int VEL_MAX    = 2047,
  parameter int DAMP_SHIFT = 0,
  parameter int REST_SHIFT = 2,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 640,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 470
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic        busy,
  output logic        done,
  input  logic [19:0] pos_x,
  input  logic [19:0] pos_y,
  input  logic [15:0] vel_x,
  input  logic [15:0] vel_y,
  input  logic [15:0] angle,
  input  logic [15:0] omega,
  input  logic [15:0] inv_mass,
  input  logic [7:0]  width,
  input  logic [7:0]  height,
  input  logic [7:0]  mass,
  input  logic [15:0] inertia,
  input  logic [15:0] inv_inertia,
  output logic [19:0] ld_pos_x,
  output logic [19:0] ld_pos_y,
  output logic [15:0] ld_vel_x,
  output logic [15:0] ld_vel_y,
  output logic [15:0] ld_angle,
  output logic [15:0] ld_omega,
  output logic [15:0] ld_inv_mass,
  output logic [7:0]  ld_width,
  output logic [7:0]  ld_height,
  output logic [7:0]  ld_mass,
  output logic [15:0] ld_inertia,
  output logic [15:0] ld_inv_inertia,
  output logic        load
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_VEL, S_POS, S_BOUND, S_WRITE
  } state_t;

  localparam logic signed [16:0] VMAX17 = 17'(VEL_MAX);
  localparam logic signed [16:0] VMIN17 = -VMAX17;
  localparam logic signed [16:0] GRAV17 = 17'(GRAVITY);
  localparam logic signed [20:0] X_LO   = 21'(X_MIN * 256);
  localparam logic signed [20:0] X_HI   = 21'(X_MAX * 256);
  localparam logic signed [20:0] Y_LO   = 21'(Y_MIN * 256);
  localparam logic signed [20:0] Y_HI   = 21'(Y_MAX * 256);

  function automatic logic [15:0] sat_vel(input logic signed [16:0] v);
    if (v > VMAX17)      return VMAX17[15:0];
    else if (v < VMIN17) return VMIN17[15:0];
    else                 return v[15:0];
  endfunction

  function automatic logic [15:0] bounce(input logic signed [15:0] v);
    logic signed [16:0] w;
    w = $signed({v[15], v});
    w = -(w - (w >>> REST_SHIFT));
    return w[15:0];
  endfunction

  state_t state_q, state_d;

  // Working registers; positions carry one extra bit so the integrate step
  // can overshoot and still be caught by the wall clamp.
  logic signed [20:0] px_q, px_d, py_q, py_d;
  logic signed [15:0] vx_q, vx_d, vy_q, vy_d;
  logic [15:0] ang_q, ang_d, om_q, om_d;
  logic [15:0] im_q, im_d, inr_q, inr_d, iinr_q, iinr_d;
  logic [7:0]  w_q, w_d, h_q, h_d, m_q, m_d;

  logic [19:0] ld_pos_x_q, ld_pos_x_d, ld_pos_y_q, ld_pos_y_d;
  logic [15:0] ld_vel_x_q, ld_vel_x_d, ld_vel_y_q, ld_vel_y_d;
  logic [15:0] ld_angle_q, ld_angle_d, ld_omega_q, ld_omega_d;
  logic [15:0] ld_inv_mass_q, ld_inv_mass_d, ld_inertia_q, ld_inertia_d;
  logic [15:0] ld_inv_inertia_q, ld_inv_inertia_d;
  logic [7:0]  ld_width_q, ld_width_d, ld_height_q, ld_height_d;
  logic [7:0]  ld_mass_q, ld_mass_d;

  always_comb begin
    state_d = state_q;
    px_d = px_q;  py_d = py_q;  vx_d = vx_q;  vy_d = vy_q;
    ang_d = ang_q;  om_d = om_q;  im_d = im_q;
    inr_d = inr_q;  iinr_d = iinr_q;  w_d = w_q;  h_d = h_q;  m_d = m_q;
    ld_pos_x_d = ld_pos_x_q;  ld_pos_y_d = ld_pos_y_q;
    ld_vel_x_d = ld_vel_x_q;  ld_vel_y_d = ld_vel_y_q;
    ld_angle_d = ld_angle_q;  ld_omega_d = ld_omega_q;
    ld_inv_mass_d = ld_inv_mass_q;  ld_inertia_d = ld_inertia_q;
    ld_inv_inertia_d = ld_inv_inertia_q;
    ld_width_d = ld_width_q;  ld_height_d = ld_height_q;  ld_mass_d = ld_mass_q;

    unique case (state_q)
      S_IDLE: if (step) state_d = S_CAPTURE;
      S_CAPTURE: begin
        px_d = $signed({pos_x[19], pos_x});
        py_d = $signed({pos_y[19], pos_y});
        vx_d = $signed(vel_x);  vy_d = $signed(vel_y);
        ang_d = angle;  om_d = omega;  im_d = inv_mass;
        inr_d = inertia;  iinr_d = inv_inertia;
        w_d = width;  h_d = height;  m_d = mass;
        state_d = S_VEL;
      end
      S_VEL: begin
        if (im_q != 16'd0) begin
          vy_d = $signed(sat_vel($signed({vy_q[15], vy_q}) + GRAV17));
          vx_d = $signed(sat_vel($signed({vx_q[15], vx_q})));
        end
        if (DAMP_SHIFT != 0) om_d = om_q - 16'($signed(om_q) >>> DAMP_SHIFT);
        state_d = S_POS;
      end
      S_POS: begin
        if (im_q != 16'd0) begin
          px_d = px_q + $signed({{5{vx_q[15]}}, vx_q});
          py_d = py_q + $signed({{5{vy_q[15]}}, vy_q});
        end
        ang_d = ang_q + om_q;
        state_d = S_BOUND;
      end
      S_BOUND: begin
        ld_pos_x_d = px_q[19:0];  ld_vel_x_d = vx_q;
        ld_pos_y_d = py_q[19:0];  ld_vel_y_d = vy_q;
        // Static bodies never move, so they are never clamped either.
        if (im_q != 16'd0) begin
          if (px_q < X_LO) begin
            ld_pos_x_d = X_LO[19:0];  ld_vel_x_d = bounce(vx_q);
          end else if (px_q > X_HI) begin
            ld_pos_x_d = X_HI[19:0];  ld_vel_x_d = bounce(vx_q);
          end
          if (py_q < Y_LO) begin
            ld_pos_y_d = Y_LO[19:0];  ld_vel_y_d = bounce(vy_q);
          end else if (py_q > Y_HI) begin
            ld_pos_y_d = Y_HI[19:0];  ld_vel_y_d = bounce(vy_q);
          end
        end
        ld_angle_d = ang_q;  ld_omega_d = om_q;
        ld_inv_mass_d = im_q;  ld_inertia_d = inr_q;  ld_inv_inertia_d = iinr_q;
        ld_width_d = w_q;  ld_height_d = h_q;  ld_mass_d = m_q;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      px_q <= '0;  py_q <= '0;  vx_q <= '0;  vy_q <= '0;
      ang_q <= '0;  om_q <= '0;  im_q <= '0;
      inr_q <= '0;  iinr_q <= '0;  w_q <= '0;  h_q <= '0;  m_q <= '0;
      ld_pos_x_q <= '0;  ld_pos_y_q <= '0;  ld_vel_x_q <= '0;  ld_vel_y_q <= '0;
      ld_angle_q <= '0;  ld_omega_q <= '0;  ld_inv_mass_q <= '0;
      ld_inertia_q <= '0;  ld_inv_inertia_q <= '0;
      ld_width_q <= '0;  ld_height_q <= '0;  ld_mass_q <= '0;
    end else begin
      state_q <= state_d;
      px_q <= px_d;  py_q <= py_d;  vx_q <= vx_d;  vy_q <= vy_d;
      ang_q <= ang_d;  om_q <= om_d;  im_q <= im_d;
      inr_q <= inr_d;  iinr_q <= iinr_d;  w_q <= w_d;  h_q <= h_d;  m_q <= m_d;
      ld_pos_x_q <= ld_pos_x_d;  ld_pos_y_q <= ld_pos_y_d;
      ld_vel_x_q <= ld_vel_x_d;  ld_vel_y_q <= ld_vel_y_d;
      ld_angle_q <= ld_angle_d;  ld_omega_q <= ld_omega_d;
      ld_inv_mass_q <= ld_inv_mass_d;  ld_inertia_q <= ld_inertia_d;
      ld_inv_inertia_q <= ld_inv_inertia_d;
      ld_width_q <= ld_width_d;  ld_height_q <= ld_height_d;  ld_mass_q <= ld_mass_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign load = (state_q == S_WRITE);
  assign done = load;

  assign ld_pos_x = ld_pos_x_q;
  assign ld_pos_y = ld_pos_y_q;
  assign ld_vel_x = ld_vel_x_q;
  assign ld_vel_y = ld_vel_y_q;
  assign ld_angle = ld_angle_q;
  assign ld_omega = ld_omega_q;
  assign ld_inv_mass = ld_inv_mass_q;
  assign ld_width = ld_width_q;
  assign ld_height = ld_height_q;
  assign ld_mass = ld_mass_q;
  assign ld_inertia = ld_inertia_q;
  assign ld_inv_inertia = ld_inv_inertia_q;

endmodule
